// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter for the single-cycle MIPS data port.
// Stores to TXDATA queue a byte in a circular FIFO. The TX FSM pops one byte
// per frame and sends it 8N1 on a registered tx line.
// Optional macro UART_TX_PARITY_EN adds an even-parity bit before the stop bit.
// With the macro defined, STATUS bit4 reads 1.
//
// Register window (BASE_ADDR, 8-byte aligned; only addr[2] is decoded):
//   +0 TXDATA : write pushes wdata[7:0]; reads 0
//   +4 STATUS : {count[11:8], parity_en[4], overflow[3], busy[2], empty[1], full[0]}
//               overflow is sticky; a load of STATUS clears it
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   addr, wdata     core ALU result and register read-data-2
//   mem_write       store strobe
//   mem_read        load strobe (used only for overflow clear-on-read)
//   rdata, sel      combinational read data and window hit for the write-back mux
//   tx, busy        serial line (idle high) and frame-in-progress flag
module mmio_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter logic [31:0] BASE_ADDR    = 32'hFFFF0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        mem_write,
  input  logic        mem_read,
  output logic [31:0] rdata,
  output logic        sel,
  output logic        tx,
  output logic        busy
);

  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);
  localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0]  CntFull  = CntW'(FIFO_DEPTH);
`ifdef UART_TX_PARITY_EN
  localparam logic ParityEn = 1'b1;
`else
  localparam logic ParityEn = 1'b0;
`endif

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e            state_q, state_d;
  logic [BaudW-1:0]  baud_q, baud_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        shift_q, shift_d;
  logic              parity_q, parity_d;
  logic              tx_q, tx_d;
  logic              ovf_q, ovf_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [7:0]        mem_q [FIFO_DEPTH];

  logic        full, empty, push_req, push, pop, ovf_set, ovf_clr, baud_end;
  logic [31:0] status;
  logic        unused_bits;

  assign unused_bits = ^{wdata[31:8], addr[1:0]};

  // Address decode and FIFO control
  assign sel      = (addr[31:3] == BASE_ADDR[31:3]);
  assign full     = (count_q == CntFull);
  assign empty    = (count_q == '0);
  assign push_req = mem_write & sel & ~addr[2];
  // Fullness is judged before this edge's pop, so a same-edge pop cannot rescue a store.
  assign push     = push_req & ~full;
  assign ovf_set  = push_req & full;
  assign ovf_clr  = mem_read & sel & addr[2];
  assign pop      = (state_q == StIdle) & ~empty;
  assign baud_end = (baud_q == BaudLast);

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Set has priority over clear-on-read
  assign ovf_d = ovf_set ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);

  always_comb begin
    status       = '0;
    status[0]    = full;
    status[1]    = empty;
    status[2]    = busy;
    status[3]    = ovf_q;
    status[4]    = ParityEn;
    status[11:8] = 4'(count_q);
  end

  assign rdata = (sel && addr[2]) ? status : 32'h0;
  assign busy  = (state_q != StIdle);
  assign tx    = tx_q;

  // TX FSM: tx_d is the line value for the state being entered, so tx is registered
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    tx_d      = tx_q;
    case (state_q)
      StIdle: begin
        tx_d = 1'b1;
        if (!empty) begin
          shift_d  = mem_q[rd_ptr_q];
          parity_d = ^mem_q[rd_ptr_q];
          baud_d   = '0;
          state_d  = StStart;
          tx_d     = 1'b0;
        end
      end
      StStart: begin
        if (baud_end) begin
          baud_d    = '0;
          bit_idx_d = '0;
          state_d   = StData;
          tx_d      = shift_q[0];
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end
      StData: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = StParity;
            tx_d    = parity_q;
`else
            state_d = StStop;
            tx_d    = 1'b1;
`endif
          end else begin
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      StParity: begin
        if (baud_end) begin
          baud_d  = '0;
          state_d = StStop;
          tx_d    = 1'b1;
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end
`endif
      StStop: begin
        if (baud_end) begin
          baud_d  = '0;
          state_d = StIdle;
          tx_d    = 1'b1;
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end
      default: begin
        baud_d  = '0;
        state_d = StIdle;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      tx_q      <= 1'b1;
      ovf_q     <= 1'b0;
      count_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      tx_q      <= tx_d;
      ovf_q     <= ovf_d;
      count_q   <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
    end
  end

  // Storage needs no reset; the pointers and count define validity
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wdata[7:0];
  end

endmodule
